// File: rtl/aes_key_expand.sv
// AES-128 key schedule: expands a cipher key into 11 round keys, borrowing SubWord from an
// external responder over a four-phase req/ack handshake.
`timescale 1ns/1ps

module aes_key_expand #(
    parameter int unsigned ROUNDS = 10
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [127:0] i_key_in,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_rk_valid,
    output logic [3:0]   o_rk_idx,
    output logic [127:0] o_rk_data,
    output logic         o_sw_req,
    output logic [31:0]  o_sw_word,
    input  logic [31:0]  i_sw_result,
    input  logic         i_sw_ack
);

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StReq,
        StRel,
        StDone
    } state_e;

    state_e       r_state;
    state_e       w_state_nxt;
    logic [127:0] r_key;
    logic [127:0] w_key_nxt;
    logic [3:0]   r_round;
    logic [3:0]   w_round_nxt;
    logic [7:0]   r_rcon;
    logic [7:0]   w_rcon_nxt;
    logic         r_rk_valid;
    logic         w_rk_valid_nxt;

    logic [31:0]  w_rot;
    logic [31:0]  w_t;
    logic [31:0]  w_n0;
    logic [31:0]  w_n1;
    logic [31:0]  w_n2;
    logic [31:0]  w_n3;
    logic [7:0]   w_xtime;

    // w3 is the least significant word of the key register.
    assign w_rot   = {r_key[23:0], r_key[31:24]};
    assign w_t     = i_sw_result ^ {r_rcon, 24'h0};
    assign w_n0    = r_key[127:96] ^ w_t;
    assign w_n1    = r_key[95:64] ^ w_n0;
    assign w_n2    = r_key[63:32] ^ w_n1;
    assign w_n3    = r_key[31:0] ^ w_n2;
    assign w_xtime = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

    always_comb begin
        w_state_nxt    = r_state;
        w_key_nxt      = r_key;
        w_round_nxt    = r_round;
        w_rcon_nxt     = r_rcon;
        w_rk_valid_nxt = 1'b0;
        case (r_state)
            StIdle: begin
                // A stale ack from a previous requester must drain before a new run starts.
                if (i_start && !i_sw_ack) begin
                    w_key_nxt      = i_key_in;
                    w_round_nxt    = 4'd0;
                    w_rcon_nxt     = 8'h01;
                    w_rk_valid_nxt = 1'b1;
                    w_state_nxt    = StLoad;
                end
            end
            StLoad: begin
                w_state_nxt = StReq;
            end
            StReq: begin
                if (i_sw_ack) begin
                    w_key_nxt      = {w_n0, w_n1, w_n2, w_n3};
                    w_rcon_nxt     = w_xtime;
                    w_round_nxt    = r_round + 4'd1;
                    w_rk_valid_nxt = 1'b1;
                    w_state_nxt    = StRel;
                end
            end
            StRel: begin
                if (!i_sw_ack) begin
                    w_state_nxt = (r_round == LAST_ROUND) ? StDone : StReq;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_key      <= '0;
            r_round    <= '0;
            r_rcon     <= 8'h01;
            r_rk_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_key      <= w_key_nxt;
            r_round    <= w_round_nxt;
            r_rcon     <= w_rcon_nxt;
            r_rk_valid <= w_rk_valid_nxt;
        end
    end

    assign o_busy     = (r_state == StLoad) || (r_state == StReq) || (r_state == StRel);
    assign o_done     = (r_state == StDone);
    assign o_rk_valid = r_rk_valid;
    assign o_rk_idx   = r_round;
    assign o_rk_data  = r_key;
    assign o_sw_req   = (r_state == StReq);
    assign o_sw_word  = (r_state == StReq) ? w_rot : 32'h0;

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- AES-128 key schedule engine; the requester for the team's req/ack SubWord block.
- Expands a 128-bit cipher key into the 11 round keys.
- Emits each round key on a one-cycle valid strobe; sits between key load logic and the round datapath's round-key store.
- Owns no S-box: every SubWord goes out over the four-phase req/ack interface to an external subword instance, whose out_word is combinational and whose ack is req registered once.

Parameters:
- ROUNDS, 10, number of expansion rounds; fixed at 10 (AES-128), other values unsupported.

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin expansion; sampled only in IDLE
- key_in  input  128  cipher key; word0 = key_in[127:96], byte order big-endian within each word; captured on accepted start
- busy  output  1  high from LOAD until last release completes
- done  output  1  one-cycle pulse after round key 10 handshake closes
- rk_valid  output  1  one-cycle strobe, round key present
- rk_idx  output  4  round index 0..10, valid with rk_valid
- rk_data  output  128  round key, same word/byte order as key_in
- sw_req  output  1  SubWord request to responder
- sw_word  output  32  SubWord operand; stable while sw_req=1
- sw_result  input  32  SubWord result; valid when sw_ack=1
- sw_ack  input  1  SubWord acknowledge

Behaviour:
- Reset values: busy=0, done=0, rk_valid=0, rk_idx=0, rk_data=0, sw_req=0, sw_word=0; state IDLE; round counter 0; rcon=8'h01.
- Outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- States: IDLE, LOAD, REQ, REL, DONE.
- IDLE: start=1 and sw_ack=0 -> capture key_in, go LOAD. The sw_ack=0 guard blocks a stale ack left over after reset.
  - start=1 with sw_ack=1 is ignored, not queued.
- LOAD, 1 cycle: rk_valid=1, rk_idx=0, rk_data=key; busy=1; go REQ.
- REQ:
  - sw_req=1, sw_word=RotWord(w3)={w3[23:0],w3[31:24]}, held constant while in REQ.
  - Stay in REQ until sw_ack=1 is sampled.
  - On that edge, with t=sw_result^{rcon,24'h0}: w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - The key register takes the new words. The next cycle shows rk_valid=1, rk_idx=round, rk_data=new key.
  - Advance rcon by xtime: shift left; on overflow XOR 8'h1B. Sequence 01,02,04,08,10,20,40,80,1B,36.
  - Increment round; go REL.
- REL: sw_req=0; wait for sw_ack=0. Then go DONE if round==10, else REQ.
  - A new request is never raised while ack is still high.
- DONE, 1 cycle: done=1, busy=0; go IDLE.
- Timing with a one-cycle responder (ack<=req):
  - start accepted on the edge ending cycle 0; LOAD in cycle 1.
  - Round r key valid in cycle 4r; each round takes 4 cycles.
  - Round 10 key in cycle 40; done in cycle 42; busy high cycles 1..41.
- Slower responders stretch REQ/REL without bound (no timeout). The emitted sequence is identical and only cycle positions change.
- start during busy is ignored; key_in changes after capture have no effect.
- rst mid-operation: next cycle all outputs take reset values, sw_req drops, and partial expansion is discarded. No done pulse for the aborted run.
- sw_ack rising outside REQ is ignored. sw_ack falling while in REQ is irrelevant, since REQ waits for a 1.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, responder = subword instance:
  - rk0 = same key in cycle 1
  - rk1 = a0fafe1788542cb123a339392a6c7605 in cycle 4
  - rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6 in cycle 40
  - done in cycle 42; exactly 11 rk_valid strobes with rk_idx 0..10
- Slow responder model, ack after 3 cycles and release after 2:
  - same 11 keys as above
  - sw_word stable whenever sw_req=1
  - sw_req never rises while sw_ack=1
- Key all-zero: rk1=62636363626363636263636362636363, rk10=b4ef5bcb3e92e21123e951cf6f8f188e.
- start pulsed at cycles 5 and 20 with a different key_in: ignored, output keys unchanged, one done only.
- rst asserted in cycle 17 (mid-REQ):
  - cycle 18: sw_req=0, busy=0, no rk_valid, no done
  - restart: start raised while sw_ack=1 is not accepted until ack falls; a subsequent full run produces correct keys.
- Back-to-back runs: start asserted in the cycle after done, with key 000102030405060708090a0b0c0d0e0f -> rk10=13111d7fe3944a17f307a78b4d2b30c5; rcon restarts at 01.
